pixel_stream_sink: RTL and testbench
====================================

Name: pixel_stream_sink

Overview:
- Consumer end of the per-pixel stream produced by the coordinate generator and the per-pixel compute pipeline.
- Accepts pixel data with first_pixel/last_re sideband, checks frame structure against its own raster counters, and emits AXI4-Stream video with tuser on start of frame and tlast on end of line.
- Resynchronises to the next frame start after any framing error.
- Sits between the pixel compute pipeline and the video DMA / VDMA input.

Parameters:
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.
- DATA_W, 24, input pixel width; must be ≤ 32.

Ports:
- out_stream_aclk  in  1  clock.
- periph_resetn  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  pixel value.
- in_first_pixel  in  1  beat is pixel (0,0) of a frame.
- in_last_re  in  1  beat is last pixel of a line.
- in_valid  in  1  input beat valid.
- in_ready  out  1  sink can accept a beat.
- out_stream_tdata  out  32  zero-extended in_data.
- out_stream_tuser  out  1  start of frame.
- out_stream_tlast  out  1  end of line.
- out_stream_tvalid  out  1  output beat valid.
- out_stream_tready  in  1  downstream accepts.
- sync_error  out  1  one-cycle pulse on framing error.

Behaviour:
- Reset (asynchronous, periph_resetn low):
  - State SEEK, x=0, y=0, buffer count=0.
  - tvalid=0, tuser=0, tlast=0, tdata=0, sync_error=0.
  - in_ready forced 0 while reset is asserted.
- Storage: 2-entry FIFO (count 0..2). Each entry holds {tdata, tuser, tlast}.
  - in_ready = (count<2).
  - tvalid = (count≠0); output shows the head entry.
- Accept/pop:
  - A beat is accepted when in_valid&&in_ready. Push and pop may occur in the same cycle; count is then unchanged.
  - Pop occurs when tvalid&&tready.
- Latency: an accepted beat appears at the output on the next cycle when the FIFO is empty.
- SEEK state:
  - Accepted beats with in_first_pixel=0 are discarded (not pushed, no error).
  - A beat with in_first_pixel=1 is pushed as (0,0) with tuser=1. Then x=1 (or x=0,y=1 if X_SIZE==1), and the state goes to RUN.
- RUN state, per accepted beat:
  - exp_first = (x==0&&y==0); exp_last = (x==X_SIZE-1).
  - If in_first_pixel==exp_first and in_last_re==exp_last:
    - Push with tuser=exp_first, tlast=exp_last.
    - Advance the raster: x+1; at x==X_SIZE-1, x=0 and y+1; at the last pixel, y wraps to 0.
  - Otherwise: sync_error=1 for one cycle.
    - If in_first_pixel=1: treat the beat as a new frame start — push with tuser=1, x=1, y=0, stay in RUN.
    - Else: drop the beat, x=y=0, go to SEEK.
- Already-buffered beats are never discarded on error.
- tready low: the FIFO holds its contents; in_ready falls when count=2. No loss, duplication or reordering.
- Reset mid-operation: buffered beats are lost; tvalid deasserts immediately (asynchronously).
- tdata = {(32-DATA_W)'b0, in_data}.

Optional Feature:
- Macro: SINK_STATS_EN.
- When defined, adds two outputs, both cleared by reset:
  - frame_count[15:0]: increments (wrapping) when a beat with tlast=1 at y==Y_SIZE-1 is pushed.
  - err_count[7:0]: increments on each sync_error pulse and saturates at 255.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package pixel_stream_pkg holds:
  - default X_SIZE/Y_SIZE constants;
  - the state enum (SEEK, RUN);
  - the packed beat struct {tdata, tuser, tlast}.
- One sub-module: skid_fifo2, the 2-entry ready/valid FIFO with count, push, pop and head outputs.

Test Plan:
All tests use X_SIZE=8, Y_SIZE=4 unless noted.
- Clean frames, tready=1, 2 full frames (64 beats) starting with first_pixel:
  - tuser on beats 0 and 32 only.
  - tlast on beats 7,15,…,63.
  - tdata equals input, 1-cycle latency, sync_error never set.
- Mid-frame start, 12 beats of a line with first_pixel=0, then a frame:
  - First 12 beats are dropped with in_ready=1 and tvalid=0.
  - Output starts with tuser=1 on the first_pixel beat.
- Backpressure, in_valid held high with tready=0 for 10 cycles:
  - Exactly 2 beats are accepted, then in_ready=0.
  - On release, the output sequence is contiguous with no gaps or duplicates.
- Early last_re at x=3, y=1:
  - sync_error pulses for 1 cycle and the beat is not output.
  - Following beats are dropped until first_pixel; output resumes with tuser=1.
- Reset asserted with 2 beats buffered:
  - tvalid=0 and in_ready=0 during reset.
  - After release, in_ready=1 and the block is in SEEK.
- SINK_STATS_EN defined:
  - After 3 clean frames, frame_count=3.
  - 300 injected errors give err_count=255.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// Shared types and defaults for the pixel stream sink.
//   X_SIZE_DEF / Y_SIZE_DEF : default raster size (pixels per line / lines per frame)
//   sink_state_e            : framing state (SEEK waits for a frame start, RUN tracks the raster)
//   beat_t                  : one buffered output beat {tdata, tuser, tlast}
package pixel_stream_pkg;

  localparam int X_SIZE_DEF = 640;
  localparam int Y_SIZE_DEF = 480;

  typedef enum logic {
    SEEK = 1'b0,
    RUN  = 1'b1
  } sink_state_e;

  typedef struct packed {
    logic [31:0] tdata;
    logic        tuser;
    logic        tlast;
  } beat_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry ready/valid FIFO holding output beats.
//   clk, rst_n : clock, asynchronous active-low reset (clears contents and count)
//   push       : write wr_beat (ignored when full)
//   wr_beat    : beat to store
//   pop        : drop the head entry (ignored when empty)
//   head       : oldest stored beat
//   count      : number of stored beats, 0..2
module skid_fifo2
  import pixel_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  beat_t      wr_beat,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] count
);

  beat_t      mem0_q, mem0_d;
  beat_t      mem1_q, mem1_d;
  logic [1:0] count_q, count_d;
  logic       do_push;
  logic       do_pop;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    do_push = push && (count_q != 2'd2);
    do_pop  = pop && (count_q != 2'd0);
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) mem0_d = wr_beat;
        else                 mem1_d = wr_beat;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        mem0_d  = mem1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          mem0_d = wr_beat;
        end else begin
          mem0_d = mem1_q;
          mem1_d = wr_beat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign head  = mem0_q;
  assign count = count_q;

endmodule

// File: rtl/pixel_stream_sink.sv
// Pixel stream sink: checks per-pixel framing sideband against local raster
// counters and emits AXI4-Stream video (tuser = start of frame, tlast = end of line).
//   out_stream_aclk, periph_resetn : clock, asynchronous active-low reset
//   in_data/in_first_pixel/in_last_re/in_valid/in_ready : pixel input handshake
//   out_stream_t* : AXI4-Stream video output
//   sync_error    : one-cycle pulse when a beat disagrees with the raster position
// Optional build macro SINK_STATS_EN adds frame_count[15:0] and err_count[7:0].
//
// state | meaning
// SEEK  | waiting for a first_pixel beat; other beats are dropped silently
// RUN   | tracking the raster; every accepted beat is checked against (x, y)
module pixel_stream_sink
  import pixel_stream_pkg::*;
#(
  parameter int X_SIZE = X_SIZE_DEF,
  parameter int Y_SIZE = Y_SIZE_DEF,
  parameter int DATA_W = 24
) (
  input  logic              out_stream_aclk,
  input  logic              periph_resetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first_pixel,
  input  logic              in_last_re,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       out_stream_tdata,
  output logic              out_stream_tuser,
  output logic              out_stream_tlast,
  output logic              out_stream_tvalid,
  input  logic              out_stream_tready,
  output logic              sync_error
`ifdef SINK_STATS_EN
  ,
  output logic [15:0]       frame_count,
  output logic [7:0]        err_count
`endif
);

  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [XW-1:0] X_LAST  = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(Y_SIZE - 1);
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);
  // Raster position right after pixel (0,0) has been taken.
  localparam logic [XW-1:0] X_START = (X_SIZE == 1) ? '0 : X_ONE;
  localparam logic [YW-1:0] Y_START = (X_SIZE == 1 && Y_SIZE > 1) ? Y_ONE : '0;
  localparam logic          LAST_AT_ORIGIN = (X_SIZE == 1);

  sink_state_e   state_q, state_d;
  logic [XW-1:0] x_q, x_d, x_adv;
  logic [YW-1:0] y_q, y_d, y_adv;
  logic          sync_error_q, sync_error_d;
  logic          exp_first, exp_last;
  logic          accept, push, pop;
  beat_t         wr_beat, head;
  logic [1:0]    count;

  skid_fifo2 u_fifo (
    .clk     (out_stream_aclk),
    .rst_n   (periph_resetn),
    .push    (push),
    .wr_beat (wr_beat),
    .pop     (pop),
    .head    (head),
    .count   (count)
  );

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state_q      <= SEEK;
      x_q          <= '0;
      y_q          <= '0;
      sync_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sync_error_q <= sync_error_d;
    end
  end

  always_comb begin
    exp_first = (x_q == '0) && (y_q == '0);
    exp_last  = (x_q == X_LAST);
    x_adv     = x_q + X_ONE;
    y_adv     = y_q;
    if (x_q == X_LAST) begin
      x_adv = '0;
      y_adv = (y_q == Y_LAST) ? '0 : y_q + Y_ONE;
    end
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    sync_error_d  = 1'b0;
    push          = 1'b0;
    wr_beat.tdata = 32'(in_data);
    wr_beat.tuser = 1'b0;
    wr_beat.tlast = 1'b0;
    if (accept) begin
      case (state_q)
        SEEK: begin
          if (in_first_pixel) begin
            push          = 1'b1;
            wr_beat.tuser = 1'b1;
            wr_beat.tlast = LAST_AT_ORIGIN;
            x_d           = X_START;
            y_d           = Y_START;
            state_d       = RUN;
          end
        end
        RUN: begin
          if (in_first_pixel == exp_first && in_last_re == exp_last) begin
            push          = 1'b1;
            wr_beat.tuser = exp_first;
            wr_beat.tlast = exp_last;
            x_d           = x_adv;
            y_d           = y_adv;
          end else begin
            sync_error_d = 1'b1;
            // A misplaced first_pixel is taken as a fresh frame start rather
            // than dropped, so the output recovers without losing a frame.
            if (in_first_pixel) begin
              push          = 1'b1;
              wr_beat.tuser = 1'b1;
              wr_beat.tlast = LAST_AT_ORIGIN;
              x_d           = X_START;
              y_d           = Y_START;
            end else begin
              x_d     = '0;
              y_d     = '0;
              state_d = SEEK;
            end
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  // in_ready is gated by the reset pin itself so it reads 0 throughout reset.
  always_comb begin
    in_ready          = periph_resetn && (count != 2'd2);
    out_stream_tvalid = (count != 2'd0);
    out_stream_tdata  = head.tdata;
    out_stream_tuser  = head.tuser;
    out_stream_tlast  = head.tlast;
    sync_error        = sync_error_q;
    accept            = in_valid && in_ready;
    pop               = out_stream_tvalid && out_stream_tready;
  end

`ifdef SINK_STATS_EN
  localparam logic ORIGIN_ENDS_FRAME = (X_SIZE == 1) && (Y_SIZE == 1);

  logic [15:0] frame_count_q, frame_count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        frame_inc;

  // Pushes from SEEK or from a resync sit on row 0; matched pushes sit on y_q.
  always_comb begin
    frame_inc = push && wr_beat.tlast &&
                ((state_q == RUN && !sync_error_d) ? (y_q == Y_LAST) : ORIGIN_ENDS_FRAME);
    frame_count_d = frame_inc ? frame_count_q + 16'd1 : frame_count_q;
    err_count_d   = (sync_error_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      frame_count_q <= 16'd0;
      err_count_q   <= 8'd0;
    end else begin
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_pixel_stream_sink.sv
module tb_pixel_stream_sink;
  localparam int X = 8;
  localparam int Y = 4;
  localparam int DW = 24;
  localparam int FRAME = X * Y;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_first = 1'b0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   out_tdata;
  logic          out_tuser;
  logic          out_tlast;
  logic          out_tvalid;
  logic          out_tready = 1'b1;
  logic          sync_error;
`ifdef SINK_STATS_EN
  logic [15:0]   frame_count;
  logic [7:0]    err_count;
`endif

  pixel_stream_sink #(.X_SIZE(X), .Y_SIZE(Y), .DATA_W(DW)) dut (
    .out_stream_aclk   (clk),
    .periph_resetn     (rst_n),
    .in_data           (in_data),
    .in_first_pixel    (in_first),
    .in_last_re        (in_last),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_stream_tdata  (out_tdata),
    .out_stream_tuser  (out_tuser),
    .out_stream_tlast  (out_tlast),
    .out_stream_tvalid (out_tvalid),
    .out_stream_tready (out_tready),
    .sync_error        (sync_error)
`ifdef SINK_STATS_EN
    ,
    .frame_count       (frame_count),
    .err_count         (err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] d;
    logic        u;
    logic        l;
    int          cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_q[$];
  int   cyc = 0;
  int   m_pos = -1;     // position inside the frame, -1 while hunting for a frame start
  int   m_err = 0;
  int   m_frames = 0;
  int   err_cycles = 0;

  always @(posedge clk) cyc++;

  // Reference model: frame position as a plain pixel index, applied to each accepted beat.
  always @(negedge clk) begin : monitor
    rec_t r;
    bit   ef, el;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        r.d = 32'(in_data);
        r.cyc = cyc;
        if (m_pos < 0) begin
          if (in_first) begin
            r.u = 1'b1; r.l = (X == 1);
            exp_q.push_back(r);
            m_pos = 1 % FRAME;
          end
        end else begin
          ef = (m_pos == 0);
          el = ((m_pos % X) == X - 1);
          if (in_first == ef && in_last == el) begin
            r.u = ef; r.l = el;
            exp_q.push_back(r);
            if (el && (m_pos / X) == Y - 1) m_frames++;
            m_pos = (m_pos + 1) % FRAME;
          end else begin
            m_err++;
            if (in_first) begin
              r.u = 1'b1; r.l = (X == 1);
              exp_q.push_back(r);
              m_pos = 1 % FRAME;
            end else begin
              m_pos = -1;
            end
          end
        end
      end
      if (out_tvalid && out_tready) begin
        r.d = out_tdata; r.u = out_tuser; r.l = out_tlast; r.cyc = cyc;
        got_q.push_back(r);
      end
      if (sync_error) err_cycles++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pos = -1; m_err = 0; m_frames = 0; err_cycles = 0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic clear_logs();
    exp_q.delete(); got_q.delete(); err_cycles = 0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic f, input logic l);
    bit ok = 1'b0;
    in_data = d; in_first = f; in_last = l; in_valid = 1'b1;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic send_frame();
    for (int p = 0; p < FRAME; p++) send(DW'($urandom), p == 0, (p % X) == X - 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    model_reset();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got %b need 0", out_tvalid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got %b need 0", in_ready); end
    checks++; if (out_tuser !== 1'b0 || out_tlast !== 1'b0) begin failures++; $display("FAIL rst_user_last got %b%b need 00", out_tuser, out_tlast); end
    checks++; if (out_tdata !== 32'd0) begin failures++; $display("FAIL rst_tdata got %h need 0", out_tdata); end
    checks++; if (sync_error !== 1'b0) begin failures++; $display("FAIL rst_sync_error got %b need 0", sync_error); end
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_tvalid !== 1'b0) begin failures++; $display("FAIL rst_release got ready=%b tvalid=%b need 1/0", in_ready, out_tvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_clean();
    out_tready = 1'b1;
    clear_logs();
    send_frame(); send_frame();
    idle(5);
    checks++; if (got_q.size() !== 2 * FRAME || exp_q.size() !== 2 * FRAME) begin failures++; $display("FAIL clean_count got %0d model %0d need %0d", got_q.size(), exp_q.size(), 2 * FRAME); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].d !== exp_q[i].d || got_q[i].u !== (i % FRAME == 0) || got_q[i].l !== (i % X == X - 1)) begin
        failures++; $display("FAIL clean_beat%0d got d=%h u=%b l=%b need d=%h u=%b l=%b", i, got_q[i].d, got_q[i].u, got_q[i].l, exp_q[i].d, i % FRAME == 0, i % X == X - 1);
      end
      checks++;
      if (got_q[i].cyc !== exp_q[i].cyc + 1) begin failures++; $display("FAIL clean_latency%0d got %0d cycles need 1", i, got_q[i].cyc - exp_q[i].cyc); end
    end
    checks++; if (err_cycles !== 0) begin failures++; $display("FAIL clean_sync_error got %0d pulses need 0", err_cycles); end
  endtask

  task automatic test_mid_frame();
    do_reset();
    clear_logs();
    for (int j = 0; j < 12; j++) begin
      send(DW'($urandom), 1'b0, ((j + 4) % X) == X - 1);
      checks++;
      if (in_ready !== 1'b1 || out_tvalid !== 1'b0) begin failures++; $display("FAIL mid_drop%0d got ready=%b tvalid=%b need 1/0", j, in_ready, out_tvalid); end
    end
    send_frame();
    idle(5);
    checks++; if (got_q.size() !== FRAME || exp_q.size() !== FRAME) begin failures++; $display("FAIL mid_count got %0d model %0d need %0d", got_q.size(), exp_q.size(), FRAME); end
    checks++; if (got_q.size() > 0 && got_q[0].u !== 1'b1) begin failures++; $display("FAIL mid_first_tuser got %b need 1", got_q[0].u); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].d !== exp_q[i].d || got_q[i].u !== exp_q[i].u || got_q[i].l !== exp_q[i].l) begin
        failures++; $display("FAIL mid_beat%0d got d=%h u=%b l=%b need d=%h u=%b l=%b", i, got_q[i].d, got_q[i].u, got_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
      end
    end
    checks++; if (err_cycles !== 0) begin failures++; $display("FAIL mid_sync_error got %0d pulses need 0", err_cycles); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] bd [FRAME];
    int k = 0;
    int acc = 0;
    bit took;
    for (int p = 0; p < FRAME; p++) bd[p] = DW'($urandom);
    clear_logs();
    out_tready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_data = bd[k]; in_first = (k == 0); in_last = (k % X == X - 1); in_valid = 1'b1;
      @(negedge clk); took = in_ready;
      @(posedge clk); #1;
      if (took) begin acc++; k++; end
    end
    checks++; if (acc !== 2) begin failures++; $display("FAIL bp_accepted got %0d need 2", acc); end
    checks++; if (in_ready !== 1'b0 || out_tvalid !== 1'b1) begin failures++; $display("FAIL bp_full got ready=%b tvalid=%b need 0/1", in_ready, out_tvalid); end
    out_tready = 1'b1;
    for (int p = k; p < FRAME; p++) send(bd[p], p == 0, (p % X) == X - 1);
    idle(5);
    checks++; if (got_q.size() !== FRAME) begin failures++; $display("FAIL bp_count got %0d need %0d", got_q.size(), FRAME); end
    for (int i = 0; i < FRAME && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].d !== 32'(bd[i]) || got_q[i].u !== exp_q[i].u || got_q[i].l !== exp_q[i].l) begin
        failures++; $display("FAIL bp_beat%0d got d=%h u=%b l=%b need d=%h u=%b l=%b", i, got_q[i].d, got_q[i].u, got_q[i].l, 32'(bd[i]), exp_q[i].u, exp_q[i].l);
      end
    end
  endtask

  task automatic test_early_last();
    out_tready = 1'b1;
    clear_logs();
    for (int p = 0; p < FRAME; p++) send(DW'($urandom), p == 0, ((p % X) == X - 1) || p == X + 3);
    send_frame();
    idle(5);
    checks++; if (err_cycles !== 1) begin failures++; $display("FAIL early_pulse got %0d cycles need 1", err_cycles); end
    checks++; if (got_q.size() !== X + 3 + FRAME || exp_q.size() !== X + 3 + FRAME) begin failures++; $display("FAIL early_count got %0d model %0d need %0d", got_q.size(), exp_q.size(), X + 3 + FRAME); end
    checks++; if (got_q.size() > X + 3 && got_q[X + 3].u !== 1'b1) begin failures++; $display("FAIL early_resume_tuser got %b need 1", got_q[X + 3].u); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].d !== exp_q[i].d || got_q[i].u !== exp_q[i].u || got_q[i].l !== exp_q[i].l) begin
        failures++; $display("FAIL early_beat%0d got d=%h u=%b l=%b need d=%h u=%b l=%b", i, got_q[i].d, got_q[i].u, got_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    out_tready = 1'b0;
    send(DW'($urandom), 1'b1, 1'b0);
    send(DW'($urandom), 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_tvalid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL rmid_full got tvalid=%b ready=%b need 1/0", out_tvalid, in_ready); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (out_tvalid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL rmid_during got tvalid=%b ready=%b need 0/0", out_tvalid, in_ready); end
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1; out_tready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_tvalid !== 1'b0) begin failures++; $display("FAIL rmid_release got ready=%b tvalid=%b need 1/0", in_ready, out_tvalid); end
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) send(DW'($urandom), 1'b0, 1'b0);
    send_frame();
    idle(5);
    checks++; if (err_cycles !== 0) begin failures++; $display("FAIL rmid_seek_error got %0d pulses need 0", err_cycles); end
    checks++; if (got_q.size() !== FRAME || exp_q.size() !== FRAME) begin failures++; $display("FAIL rmid_count got %0d model %0d need %0d", got_q.size(), exp_q.size(), FRAME); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].d !== exp_q[i].d || got_q[i].u !== exp_q[i].u || got_q[i].l !== exp_q[i].l) begin
        failures++; $display("FAIL rmid_beat%0d got d=%h u=%b l=%b need d=%h u=%b l=%b", i, got_q[i].d, got_q[i].u, got_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
      end
    end
  endtask

`ifdef SINK_STATS_EN
  task automatic test_stats();
    out_tready = 1'b1;
    do_reset();
    checks++; if (frame_count !== 16'd0 || err_count !== 8'd0) begin failures++; $display("FAIL stats_reset got fc=%0d ec=%0d need 0/0", frame_count, err_count); end
    repeat (3) send_frame();
    idle(4);
    checks++; if (frame_count !== 16'(m_frames) || m_frames !== 3) begin failures++; $display("FAIL stats_frames got %0d model %0d need 3", frame_count, m_frames); end
    for (int j = 0; j < 301; j++) send(DW'($urandom), 1'b1, 1'b0);
    idle(4);
    checks++; if (err_count !== 8'((m_err > 255) ? 255 : m_err) || m_err !== 300) begin failures++; $display("FAIL stats_errs got %0d model %0d need 255", err_count, m_err); end
    checks++; if (frame_count !== 16'd3) begin failures++; $display("FAIL stats_frames_hold got %0d need 3", frame_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_clean();
    test_mid_frame();
    test_backpressure();
    test_early_last();
    test_reset_mid();
`ifdef SINK_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
